generador_morse: RTL

- Morse transmitter for the sound path: accepts one character code at a time over a valid/ready handshake.
- Looks the code up in a Morse table and plays out its dots and dashes as timed `short`/`long` pulses, with standard symbol, character and word gaps.
- Drives the `short`/`long` inputs of the sound module, replacing the push-button source, so stored text is keyed automatically.

---
 rtl/morse_pkg.sv | 19 +
 rtl/morse_tabla.sv | 48 ++++
 rtl/generador_morse.sv | 72 +++++++
 3 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared states, code constants, unit counts and pattern type for the Morse keyer
package morse_pkg;
  typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] sym;
  } pattern_t;
  localparam logic [5:0] CODE_SPACE      = 6'd36;
  localparam logic [5:0] CODE_LAST_VALID = 6'd36;
  localparam logic [2:0] DOT_UNITS       = 3'd1;
  localparam logic [2:0] DASH_UNITS      = 3'd3;
  localparam logic [2:0] SYM_GAP         = 3'd1;
  localparam logic [2:0] CHAR_GAP_EXTRA  = 3'd2;
  localparam logic [2:0] WORD_GAP_EXTRA  = 3'd4;
  // Symbols are written right-aligned for readability and stored left-aligned so symbol 0 is bit 4
  function automatic pattern_t mk(input logic [2:0] l, input logic [4:0] b);
    return '{len: l, sym: b << (3'd5 - l)};
  endfunction
endpackage

// File: rtl/morse_tabla.sv
// morse_tabla: combinational Morse ROM, 1 = dash, first symbol in the MSB
module morse_tabla
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output pattern_t   pat
);
  always_comb
    case (code)
      6'd0:  pat = mk(3'd2, 5'b01);
      6'd1:  pat = mk(3'd4, 5'b1000);
      6'd2:  pat = mk(3'd4, 5'b1010);
      6'd3:  pat = mk(3'd3, 5'b100);
      6'd4:  pat = mk(3'd1, 5'b0);
      6'd5:  pat = mk(3'd4, 5'b0010);
      6'd6:  pat = mk(3'd3, 5'b110);
      6'd7:  pat = mk(3'd4, 5'b0000);
      6'd8:  pat = mk(3'd2, 5'b00);
      6'd9:  pat = mk(3'd4, 5'b0111);
      6'd10: pat = mk(3'd3, 5'b101);
      6'd11: pat = mk(3'd4, 5'b0100);
      6'd12: pat = mk(3'd2, 5'b11);
      6'd13: pat = mk(3'd2, 5'b10);
      6'd14: pat = mk(3'd3, 5'b111);
      6'd15: pat = mk(3'd4, 5'b0110);
      6'd16: pat = mk(3'd4, 5'b1101);
      6'd17: pat = mk(3'd3, 5'b010);
      6'd18: pat = mk(3'd3, 5'b000);
      6'd19: pat = mk(3'd1, 5'b1);
      6'd20: pat = mk(3'd3, 5'b001);
      6'd21: pat = mk(3'd4, 5'b0001);
      6'd22: pat = mk(3'd3, 5'b011);
      6'd23: pat = mk(3'd4, 5'b1001);
      6'd24: pat = mk(3'd4, 5'b1011);
      6'd25: pat = mk(3'd4, 5'b1100);
      6'd26: pat = mk(3'd5, 5'b11111);
      6'd27: pat = mk(3'd5, 5'b01111);
      6'd28: pat = mk(3'd5, 5'b00111);
      6'd29: pat = mk(3'd5, 5'b00011);
      6'd30: pat = mk(3'd5, 5'b00001);
      6'd31: pat = mk(3'd5, 5'b00000);
      6'd32: pat = mk(3'd5, 5'b10000);
      6'd33: pat = mk(3'd5, 5'b11000);
      6'd34: pat = mk(3'd5, 5'b11100);
      6'd35: pat = mk(3'd5, 5'b11110);
      default: pat = '0;
    endcase
endmodule

// File: rtl/generador_morse.sv
// generador_morse: keys one character code at a time as timed short/long pulses with Morse gaps
module generador_morse
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       short,
  output logic       long,
  output logic       busy
);
  localparam int CW = $clog2(UNIT_CYCLES + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    unit_q, unit_d, idx_q, idx_d, units;
  pattern_t      pat_q, pat_d, rom;
  logic          accept, dash, unit_end, state_end, last_sym;

  morse_tabla u_tabla (.code(char_code), .pat(rom));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
    end

  always_comb begin
    accept    = char_valid && char_code <= CODE_LAST_VALID;
    dash      = pat_q.sym[3'd4 - idx_q];
    units     = state_q == MARK ? (dash ? DASH_UNITS : DOT_UNITS) :
                state_q == GAP ? SYM_GAP :
                state_q == CHAR_GAP ? CHAR_GAP_EXTRA : WORD_GAP_EXTRA;
    unit_end  = cyc_q == CW'(UNIT_CYCLES - 1);
    state_end = unit_end && unit_q == units - 3'd1;
    last_sym  = idx_q == pat_q.len - 3'd1;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (char_code == CODE_SPACE ? WORD_GAP : MARK) : IDLE;
      MARK:    state_d = state_end ? GAP : MARK;
      GAP:     state_d = state_end ? (last_sym ? CHAR_GAP : MARK) : GAP;
      default: state_d = state_end ? IDLE : state_q;
    endcase
  end

  // Every transition changes state, so a state change is exactly a state entry
  always_comb begin
    pat_d  = state_q == IDLE && accept ? rom : pat_q;
    idx_d  = state_q == IDLE ? 3'd0 : state_q == GAP && state_end ? idx_q + 3'd1 : idx_q;
    cyc_d  = state_d != state_q || unit_end || state_q == IDLE ? '0 : cyc_q + 1'b1;
    unit_d = state_d != state_q || state_q == IDLE ? 3'd0 : unit_end ? unit_q + 3'd1 : unit_q;
  end

  always_comb begin
    char_ready = state_q == IDLE;
    busy       = state_q != IDLE;
    short      = state_q == MARK && !dash;
    long       = state_q == MARK && dash;
  end
endmodule
